// File: rtl/lfsr_prng_pkg.sv
// Shared types and the LFSR step function for the pseudo-random generator.
// The step function is also used by the bench reference model.
package lfsr_pkg;

    localparam int unsigned LFSR_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RECOVER = 2'd2
    } lfsr_fsm_t;

    // State is passed zero-extended to 32 bits; width selects the live bits.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] s,
        input logic [LFSR_MAX_W-1:0] taps,
        input int unsigned           width,
        input logic                  galois
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic [LFSR_MAX_W-1:0] shifted;
        logic [LFSR_MAX_W-1:0] msb_vec;
        mask    = (width >= LFSR_MAX_W) ? 32'hFFFF_FFFF : ((32'h0000_0001 << width) - 32'h0000_0001);
        shifted = (s << 1) & mask;
        msb_vec = s >> (width - 32'd1);
        if (galois) begin
            if (msb_vec[0]) begin
                lfsr_next = shifted ^ (taps & mask);
            end else begin
                lfsr_next = shifted;
            end
        end else begin
            lfsr_next = shifted | {31'h0000_0000, ^(s & taps & mask)};
        end
    endfunction

endpackage

// File: rtl/lfsr_prng_if.sv
// Output handshake, seed load and period monitor signals of the LFSR generator.
interface lfsr_prng_if #(
    parameter int unsigned WIDTH = 16
);
    logic             seed_valid;
    logic [WIDTH-1:0] seed_data;
    logic             dout_valid;
    logic             dout_ready;
    logic [WIDTH-1:0] dout;
    logic             lockup;
    logic             period_wrap;
    logic [WIDTH-1:0] period;

    modport master (
        input  seed_valid, seed_data, dout_ready,
        output dout_valid, dout, lockup, period_wrap, period
    );

    modport slave (
        output seed_valid, seed_data, dout_ready,
        input  dout_valid, dout, lockup, period_wrap, period
    );
endinterface

// File: rtl/lfsr_prng_period_mon.sv
// Cycle-period monitor: counts accepted steps since the reference value and
// reports the count when the sequence comes back to it.
module lfsr_period_mon
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = 16'h0001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             recover,
    input  logic             advance,
    input  logic [WIDTH-1:0] next_state,
    output logic [WIDTH-1:0] period,
    output logic             period_wrap
);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] cnt_inc_s;

    // Saturating so a non-invertible tap mask never fakes a wrap.
    assign cnt_inc_s = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + CNT_ONE);

    // Next-state selection for counter, reference and period outputs.
    always_comb begin
        cnt_d    = cnt_q;
        ref_d    = ref_q;
        period_d = period_q;
        wrap_d   = 1'b0;
        if (load) begin
            ref_d = load_value;
            cnt_d = CNT_ZERO;
        end else if (recover) begin
            ref_d = SEED;
            cnt_d = CNT_ZERO;
        end else if (advance) begin
            if (next_state == ref_q) begin
                period_d = cnt_inc_s;
                cnt_d    = CNT_ZERO;
                wrap_d   = 1'b1;
            end else begin
                cnt_d = cnt_inc_s;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Monitor registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= CNT_ZERO;
            ref_q    <= SEED;
            period_q <= CNT_ZERO;
            wrap_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ref_q    <= ref_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
        end
    end

    assign period      = period_q;
    assign period_wrap = wrap_q;

endmodule

// File: rtl/lfsr_prng.sv
// Parametrised Fibonacci/Galois LFSR generator with valid/ready output,
// run-time reseeding, all-zero lock-up recovery and period measurement.
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH  = 16,
    parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
    parameter logic [WIDTH-1:0] SEED   = 16'h0001,
    parameter bit               GALOIS = 1'b0
) (
    input logic         clk,
    input logic         reset,
    lfsr_prng_if.master bus
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    lfsr_fsm_t        fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic             dout_valid_q, dout_valid_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] next_s;
    logic             load_s;
    logic             advance_s;
    logic             recover_s;
    logic [WIDTH-1:0] period_s;
    logic             period_wrap_s;

    assign next_s    = WIDTH'(lfsr_next(32'(state_q), 32'(TAPS), WIDTH, GALOIS));
    assign load_s    = bus.seed_valid;
    assign advance_s = (fsm_q == ST_RUN) && dout_valid_q && bus.dout_ready && !load_s;
    assign recover_s = (fsm_q == ST_RECOVER) && !load_s;

    // FSM, state and handshake next-value logic; a seed load overrides everything.
    always_comb begin
        fsm_d        = fsm_q;
        state_d      = state_q;
        dout_valid_d = dout_valid_q;
        lockup_d     = 1'b0;
        if (load_s) begin
            state_d      = bus.seed_data;
            fsm_d        = ST_INIT;
            dout_valid_d = 1'b0;
        end else begin
            case (fsm_q)
                ST_INIT: begin
                    if (state_q == ZERO) begin
                        fsm_d        = ST_RECOVER;
                        dout_valid_d = 1'b0;
                    end else begin
                        fsm_d        = ST_RUN;
                        dout_valid_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (advance_s) begin
                        state_d = next_s;
                        // Never present an all-zero word as valid.
                        if (next_s == ZERO) begin
                            fsm_d        = ST_RECOVER;
                            dout_valid_d = 1'b0;
                        end else begin
                            fsm_d        = ST_RUN;
                            dout_valid_d = 1'b1;
                        end
                    end else begin
                        fsm_d        = ST_RUN;
                        dout_valid_d = 1'b1;
                    end
                end
                ST_RECOVER: begin
                    state_d      = SEED;
                    fsm_d        = ST_RUN;
                    dout_valid_d = 1'b1;
                    lockup_d     = 1'b1;
                end
                default: begin
                    state_d      = SEED;
                    fsm_d        = ST_INIT;
                    dout_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Core registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q        <= ST_INIT;
            state_q      <= SEED;
            dout_valid_q <= 1'b0;
            lockup_q     <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            state_q      <= state_d;
            dout_valid_q <= dout_valid_d;
            lockup_q     <= lockup_d;
        end
    end

    lfsr_period_mon #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_period_mon (
        .clk         (clk),
        .reset       (reset),
        .load        (load_s),
        .load_value  (bus.seed_data),
        .recover     (recover_s),
        .advance     (advance_s),
        .next_state  (next_s),
        .period      (period_s),
        .period_wrap (period_wrap_s)
    );

    assign bus.dout        = state_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.lockup      = lockup_q;
    assign bus.period      = period_s;
    assign bus.period_wrap = period_wrap_s;

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed bench: three 4-bit generators (two Fibonacci, one Galois) checked
// against hand-computed sequences, backpressure, reseeding, zero seed and reset.
module tb_lfsr_prng;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    lfsr_prng_if #(.WIDTH(4)) if_a ();
    lfsr_prng_if #(.WIDTH(4)) if_b ();
    lfsr_prng_if #(.WIDTH(4)) if_c ();

    lfsr_prng #(.WIDTH(4), .TAPS(4'b1010), .SEED(4'h1), .GALOIS(1'b0))
        u_dut_a (.clk(clk), .reset(reset), .bus(if_a));
    lfsr_prng #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'h1), .GALOIS(1'b0))
        u_dut_b (.clk(clk), .reset(reset), .bus(if_b));
    lfsr_prng #(.WIDTH(4), .TAPS(4'b0011), .SEED(4'h1), .GALOIS(1'b1))
        u_dut_c (.clk(clk), .reset(reset), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  a_seq [0:5]  = '{4'h1, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};
    logic [3:0]  b_seq [0:15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                  4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    logic [3:0]  c_seq [0:15] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                                  4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};
    logic [3:0]  s9_seq [0:6] = '{4'h9, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h9};
    logic [19:0] bp_pat       = 20'b1011_0010_1110_0101_1001;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int idx;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        if_a.seed_valid = 1'b0; if_a.seed_data = 4'h0; if_a.dout_ready = 1'b1;
        if_b.seed_valid = 1'b0; if_b.seed_data = 4'h0; if_b.dout_ready = 1'b1;
        if_c.seed_valid = 1'b0; if_c.seed_data = 4'h0; if_c.dout_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("rst_valid", 32'(if_a.dout_valid), 32'h0);
        chk("rst_dout",  32'(if_a.dout), 32'h1);
        chk("rst_period", 32'(if_a.period), 32'h0);
        chk("rst_lockup", 32'(if_a.lockup), 32'h0);
        chk("rst_wrap",  32'(if_a.period_wrap), 32'h0);
        chk("rst_valid_c", 32'(if_c.dout_valid), 32'h0);
        @(negedge clk);

        // Free-running sequences with ready held high.
        for (int i = 0; i < 16; i++) begin
            chk("a_valid", 32'(if_a.dout_valid), 32'h1);
            chk("a_seq", 32'(if_a.dout), 32'(a_seq[i % 6]));
            chk("a_wrap", 32'(if_a.period_wrap), ((i == 6) || (i == 12)) ? 32'h1 : 32'h0);
            chk("b_seq", 32'(if_b.dout), 32'(b_seq[i]));
            chk("b_wrap", 32'(if_b.period_wrap), (i == 15) ? 32'h1 : 32'h0);
            chk("c_seq", 32'(if_c.dout), 32'(c_seq[i]));
            chk("c_wrap", 32'(if_c.period_wrap), (i == 15) ? 32'h1 : 32'h0);
            if (i == 6) chk("a_period", 32'(if_a.period), 32'h6);
            if (i == 15) begin
                chk("b_period", 32'(if_b.period), 32'hF);
                chk("c_period", 32'(if_c.period), 32'hF);
            end
            @(negedge clk);
        end

        // Backpressure: accepted words must follow the orbit with no drop or repeat.
        idx = 16;
        for (int k = 0; k < 20; k++) begin
            chk("bp_valid", 32'(if_a.dout_valid), 32'h1);
            chk("bp_dout", 32'(if_a.dout), 32'(a_seq[idx % 6]));
            if_a.dout_ready = bp_pat[k];
            @(negedge clk);
            if (bp_pat[k]) idx++;
        end

        // Seed load coinciding with an accept: step discarded, orbit from 9.
        if_a.dout_ready = 1'b1;
        if_a.seed_valid = 1'b1;
        if_a.seed_data  = 4'h9;
        @(negedge clk);
        if_a.seed_valid = 1'b0;
        chk("seed_valid_low", 32'(if_a.dout_valid), 32'h0);
        chk("seed_dout", 32'(if_a.dout), 32'h9);
        @(negedge clk);
        for (int j = 0; j < 7; j++) begin
            chk("s9_valid", 32'(if_a.dout_valid), 32'h1);
            chk("s9_seq", 32'(if_a.dout), 32'(s9_seq[j]));
            chk("s9_wrap", 32'(if_a.period_wrap), (j == 6) ? 32'h1 : 32'h0);
            if (j == 6) chk("s9_period", 32'(if_a.period), 32'h6);
            @(negedge clk);
        end

        // Zero seed: INIT -> RECOVER -> RUN with SEED and one lockup pulse.
        if_a.seed_valid = 1'b1;
        if_a.seed_data  = 4'h0;
        @(negedge clk);
        if_a.seed_valid = 1'b0;
        chk("z0_valid", 32'(if_a.dout_valid), 32'h0);
        chk("z0_lockup", 32'(if_a.lockup), 32'h0);
        @(negedge clk);
        chk("z1_valid", 32'(if_a.dout_valid), 32'h0);
        chk("z1_lockup", 32'(if_a.lockup), 32'h0);
        @(negedge clk);
        chk("z2_valid", 32'(if_a.dout_valid), 32'h1);
        chk("z2_dout", 32'(if_a.dout), 32'h1);
        chk("z2_lockup", 32'(if_a.lockup), 32'h1);
        @(negedge clk);
        chk("z3_dout", 32'(if_a.dout), 32'h2);
        chk("z3_lockup", 32'(if_a.lockup), 32'h0);

        // Reset mid-stream wins over a simultaneous seed load.
        @(negedge clk);
        reset = 1'b1;
        if_a.seed_valid = 1'b1;
        if_a.seed_data  = 4'h5;
        @(negedge clk);
        chk("mr_valid", 32'(if_a.dout_valid), 32'h0);
        chk("mr_dout", 32'(if_a.dout), 32'h1);
        chk("mr_period", 32'(if_a.period), 32'h0);
        reset = 1'b0;
        if_a.seed_valid = 1'b0;
        @(negedge clk);
        chk("mr_run_valid", 32'(if_a.dout_valid), 32'h1);
        chk("mr_run_dout", 32'(if_a.dout), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
